// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
// Coin encodings, sequencer states and product ids.
package vend_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_ONE  = 2'b01;
   localparam logic [1:0] COIN_TWO  = 2'b10;

   localparam logic PROD_A = 1'b0;
   localparam logic PROD_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DISPENSE,
      CHANGE
   } state_e;

   // 2'b11 is a reserved code and counts as no coin
   function automatic logic [1:0] coin_val(input logic [1:0] c);
      coin_val = 2'd0;
      unique case (1'b1)
         (c == COIN_ONE): coin_val = 2'd1;
         (c == COIN_TWO): coin_val = 2'd2;
         default: coin_val = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_if.sv
// Front-end and mechanics signals of the vending sequencer.
// master = coin acceptor/keypad/motors side, slave = sequencer.
interface vend_if #(parameter int CREDIT_W = 4);

   logic [1:0]          coin;
   logic                sel_valid;
   logic                sel_id;
   logic                cancel;
   logic                disp_req;
   logic                disp_id;
   logic                disp_ack;
   logic                chg_req;
   logic                chg_ack;
   logic [CREDIT_W-1:0] credit;
   logic                busy;
   logic                coin_rej;

   modport master (
      output coin, sel_valid, sel_id, cancel,
      output disp_ack, chg_ack,
      input  disp_req, disp_id, chg_req,
      input  credit, busy, coin_rej
   );

   modport slave (
      input  coin, sel_valid, sel_id, cancel,
      input  disp_ack, chg_ack,
      output disp_req, disp_id, chg_req,
      output credit, busy, coin_rej
   );

endinterface

// File: rtl/vend_timeout_ctr.sv
// Inactivity counter; expired flags the last idle cycle.
module vend_timeout_ctr #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + TO_W'(1);
      end
   end

   assign expired = (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/vend_ctrl.sv
// Two-product vending sequencer: credit, dispense and
// one-coin-at-a-time change handshakes, cancel/timeout refund.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int PRICE_A  = 3,
   parameter int PRICE_B  = 5,
   parameter int CREDIT_W = 4,
   parameter int TIMEOUT  = 255,
   parameter int TO_W     = 8
) (
   input logic   clk,
   input logic   rst,
   vend_if.slave bus
);

   localparam logic [CREDIT_W:0] MAX_CR =
      {1'b0, {CREDIT_W{1'b1}}};

   state_e              state;
   logic [CREDIT_W-1:0] credit;
   logic                disp_id;
   logic                coin_rej;

   logic [1:0]          cv;
   logic [CREDIT_W-1:0] cv_w;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W-1:0] cr_in;
   logic [CREDIT_W-1:0] price;
   logic                open;
   logic                coin_acc;
   logic                afford;
   logic                expired;
   logic                tmr_en;
   logic                tmr_clr;

   assign cv     = coin_val(bus.coin);
   assign cv_w   = CREDIT_W'(cv);
   assign sum    = {1'b0, credit} + {1'b0, cv_w};
   assign open   = (state == IDLE) || (state == COLLECT);

   // overflow is judged on the pre-purchase credit
   assign coin_acc = open && (cv != 2'd0) && (sum <= MAX_CR);
   assign cr_in    = coin_acc ? sum[CREDIT_W-1:0] : credit;

   assign price  = bus.sel_id ? CREDIT_W'(PRICE_B)
                              : CREDIT_W'(PRICE_A);
   assign afford = (credit >= price);

   assign tmr_en  = (state == COLLECT);
   assign tmr_clr = !tmr_en || coin_acc;

   vend_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_tmr (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         credit   <= '0;
         disp_id  <= PROD_A;
         coin_rej <= 1'b0;
      end else begin
         coin_rej <= (cv != 2'd0) && !coin_acc;
         unique case (state)
            IDLE: begin
               if (coin_acc) begin
                  credit <= cv_w;
                  state  <= COLLECT;
               end
            end
            COLLECT: begin
               credit <= cr_in;
               if (bus.cancel) begin
                  state <= (cr_in != '0) ? CHANGE : IDLE;
               end else if (bus.sel_valid && afford) begin
                  credit  <= cr_in - price;
                  disp_id <= bus.sel_id;
                  state   <= DISPENSE;
               end else if (expired && !coin_acc) begin
                  state <= CHANGE;
               end
            end
            DISPENSE: begin
               if (bus.disp_ack) begin
                  state <= (credit != '0) ? CHANGE : IDLE;
               end
            end
            CHANGE: begin
               if (bus.chg_ack) begin
                  credit <= credit - CREDIT_W'(1);
                  if (credit == CREDIT_W'(1)) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.disp_req = (state == DISPENSE);
   assign bus.chg_req  = (state == CHANGE);
   assign bus.busy     = (state == DISPENSE) ||
                         (state == CHANGE);
   assign bus.credit   = credit;
   assign bus.disp_id  = disp_id;
   assign bus.coin_rej = coin_rej;

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Top-level vending sequencer for a two-product machine.
- Accumulates coin credit and accepts a product selection.
- Drives the dispense motor through a req/ack handshake.
- Returns change one 1-unit coin at a time through a second req/ack handshake.
- Refunds credit on cancel or on inactivity timeout.
- Sits between the coin acceptor/keypad front end and the dispense/change mechanics.

Parameters:
PRICE_A, 3, price of product A in units
PRICE_B, 5, price of product B in units
CREDIT_W, 4, credit register width; max credit = 2^CREDIT_W-1
TIMEOUT, 255, idle cycles in COLLECT before automatic refund
TO_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
coin  in  2  2'b01 = 1 unit, 2'b10 = 2 units, 2'b00/2'b11 = no coin; sampled every cycle
sel_valid  in  1  product selection strobe, one cycle
sel_id  in  1  0 = product A, 1 = product B
cancel  in  1  refund request, one cycle
disp_req  out  1  dispense request, held until disp_ack
disp_id  out  1  product being dispensed
disp_ack  in  1  motor done, one cycle
chg_req  out  1  return one 1-unit coin, held while change is owed
chg_ack  in  1  one coin returned
credit  out  CREDIT_W  current credit
busy  out  1  high in DISPENSE or CHANGE
coin_rej  out  1  one-cycle pulse; a valid coin was refused

Behaviour:
- States: IDLE, COLLECT, DISPENSE, CHANGE. The state register, credit, disp_id and the timeout counter update on posedge clk.
- Reset (rst=1 at clk edge): state=IDLE, credit=0, disp_id=0, timer=0, coin_rej=0.
  - Outputs disp_req, chg_req and busy decode from state, so all are 0 after reset.
  - Reset mid-DISPENSE or mid-CHANGE abandons the operation; the credit is lost.
- coin_val = 1 for 01, 2 for 10, else 0.
- IDLE:
  - If coin_val>0: credit <= coin_val, go to COLLECT, timer <= 0.
  - sel_valid and cancel are ignored.
- COLLECT. Priority per cycle is cancel > sel_valid > timeout. A coin arriving in the same cycle is still added unless rejected.
  - cancel: credit <= credit + coin_val, go to CHANGE. If the resulting credit is 0, go to IDLE.
  - sel_valid with credit >= price(sel_id): the comparison uses the pre-coin credit.
    - credit <= credit - price + coin_val, disp_id <= sel_id, go to DISPENSE.
  - sel_valid with insufficient credit: no state change; the coin, if any, is still added.
  - Timer increments each cycle and clears on any accepted coin. When timer == TIMEOUT-1 with no coin that cycle: go to CHANGE.
- Coin overflow: if credit + coin_val would exceed 2^CREDIT_W-1, the coin is refused.
  - coin_rej pulses high the next cycle.
  - credit is unchanged by that coin.
- DISPENSE:
  - disp_req=1 and disp_id stable until disp_ack.
  - On disp_ack: go to CHANGE if credit>0, else IDLE.
  - All coins are refused with coin_rej; sel_valid and cancel are ignored.
- CHANGE:
  - chg_req=1. Each cycle with chg_ack, credit <= credit-1.
  - On chg_ack with credit==1: go to IDLE; chg_req is 0 the next cycle.
  - Coins are refused with coin_rej.
- disp_ack or chg_ack outside its own state is ignored.
- Latency:
  - A coin is visible on credit 1 cycle after sampling.
  - disp_req rises 1 cycle after an accepted sel_valid.
  - chg_req rises 1 cycle after the disp_ack, cancel or timeout that triggers the refund.

Decomposition:
- Package vend_pkg holds:
  - coin encodings COIN_NONE/COIN_ONE/COIN_TWO;
  - the state enum (IDLE, COLLECT, DISPENSE, CHANGE);
  - the product id constants PROD_A/PROD_B.
- Sub-module vend_timeout_ctr: TO_W-bit counter with clear/enable inputs and an expired output equal to (count == TIMEOUT-1).
- All other logic lives in vend_ctrl.

Test Plan:
1. Defaults. Coins 10, 10 → credit 4. sel A → credit 1, disp_req=1, disp_id=0. disp_ack after 3 cycles → chg_req=1. One chg_ack → credit 0, IDLE, chg_req=0.
2. Coins 01, 10 → credit 3. sel B → ignored, credit 3, no disp_req. Coin 10 → credit 5. sel B → DISPENSE with credit 0. disp_ack → IDLE, chg_req never asserted.
3. Credit 4, then cancel → CHANGE. chg_ack on alternate cycles → credit 3, 2, 1, 0, then IDLE. busy high throughout.
4. Coin 01, then 255 idle cycles → CHANGE on the timeout. One chg_ack → IDLE. Coin at cycle 200 restarts the count instead.
5. Credit 14, coin 10 → coin_rej pulse, credit stays 14. Coin 01 → credit 15.
6. Coin 10 during DISPENSE → coin_rej, credit unchanged. rst asserted mid-CHANGE with credit 3 → IDLE, credit 0, chg_req 0 next cycle.
